// File: rtl/sw_pkg.sv
// Shared types and constants for the mm:ss stopwatch controller.
package sw_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StDone
  } sw_state_e;

  localparam int unsigned LimUnits = 9;
  localparam int unsigned LimTens  = 5;

  // Terminal displays and the values one tick before them.
  localparam logic [15:0] DigMax      = 16'h5959;
  localparam logic [15:0] DigMin      = 16'h0000;
  localparam logic [15:0] DigUpLast   = 16'h5958;
  localparam logic [15:0] DigDownLast = 16'h0001;

endpackage

// File: rtl/stopwatch_digit.sv
// One BCD digit counting modulo LIM+1 in either direction, with saturating load.
module stopwatch_digit
  import sw_pkg::*;
#(
  parameter int unsigned LIM = LimUnits
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       clr,
  output logic [3:0] val,
  output logic       co
);

  localparam logic [3:0] Lim = 4'(LIM);

  // Carry (up) or borrow (down) into the next digit when this one wraps.
  always_comb begin
    co = en && (dir ? (val == Lim) : (val == 4'd0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val <= 4'd0;
    end else if (clr) begin
      val <= 4'd0;
    end else if (load) begin
      val <= (load_val > Lim) ? Lim : load_val;
    end else if (en) begin
      if (dir) begin
        val <= (val == Lim) ? 4'd0 : val + 4'd1;
      end else begin
        val <= (val == 4'd0) ? Lim : val - 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Up/down mm:ss stopwatch: prescaler, command FSM and a four-digit BCD chain.
module stopwatch_ctrl
  import sw_pkg::*;
#(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        Start,
  input  logic        Stop,
  input  logic        Clr,
  input  logic        Load,
  input  logic        M,
  input  logic [15:0] Pre,
  output logic [15:0] Dig,
  output logic        Running,
  output logic        Done
);

  localparam int unsigned   CntW   = $clog2(DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  sw_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic            dir_q;
  logic            running_q;
  logic            done_q;

  logic            load_ok;
  logic            start_ok;
  logic            stop_ok;
  logic            tick;
  logic            count_en;
  logic            start_at_term;
  logic            tick_at_term;
  logic [3:0]      en;
  logic [3:0]      co;
  logic            unused_wrap;

  // Commands never collide across states except Load/Start and Clr/anything.
  always_comb begin
    load_ok       = Load && !Clr && (state_q != StRun);
    start_ok      = Start && !Clr && !Load && ((state_q == StIdle) || (state_q == StPause));
    stop_ok       = Stop && !Clr && (state_q == StRun);
    tick          = (state_q == StRun) && (cnt_q == CntMax);
    count_en      = tick && !Clr && !Stop;
    start_at_term = M ? (Dig == DigMax) : (Dig == DigMin);
    tick_at_term  = dir_q ? (Dig == DigUpLast) : (Dig == DigDownLast);
  end

  always_comb begin
    en[0] = count_en;
    en[1] = co[0];
    en[2] = co[1];
    en[3] = co[2];
  end

  assign unused_wrap = co[3];

  for (genvar i = 0; i < 4; i++) begin : g_digit
    // Even positions are units (0..9), odd positions are tens (0..5).
    localparam int unsigned DigLim = (i % 2 == 0) ? LimUnits : LimTens;

    stopwatch_digit #(
      .LIM(DigLim)
    ) u_digit (
      .clk     (CLK),
      .rst_n   (nRST),
      .en      (en[i]),
      .dir     (dir_q),
      .load    (load_ok),
      .load_val(Pre[4*i +: 4]),
      .clr     (Clr),
      .val     (Dig[4*i +: 4]),
      .co      (co[i])
    );
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      dir_q     <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (Clr || load_ok) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        running_q <= 1'b0;
      end else if (stop_ok) begin
        // Stop beats a coincident tick: prescaler and digits both hold.
        state_q   <= StPause;
        running_q <= 1'b0;
      end else if (start_ok) begin
        dir_q <= M;
        if (start_at_term) begin
          state_q   <= StDone;
          cnt_q     <= '0;
          running_q <= 1'b0;
          done_q    <= 1'b1;
        end else begin
          state_q   <= StRun;
          running_q <= 1'b1;
        end
      end else if (state_q == StRun) begin
        if (tick) begin
          cnt_q <= '0;
          if (tick_at_term) begin
            state_q   <= StDone;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign Running = running_q;
  assign Done    = done_q;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50_000_000: clock cycles per count tick, minimum 2.
REQ-002 SHALL have port CLK  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Start  input  1  level, synchronous: begin/resume counting.
REQ-005 SHALL have port Stop  input  1  level, synchronous: pause counting.
REQ-006 SHALL have port Clr  input  1  level, synchronous: clear digits to 00:00.
REQ-007 SHALL have port Load  input  1  level, synchronous: load Pre into digits.
REQ-008 SHALL have port M  input  1  direction, 1 = up, 0 = down; sampled only on Start acceptance.
REQ-009 SHALL have port Pre  input  16  BCD preset {MT,MU,ST,SU}, 4 bits each.
REQ-010 SHALL have port Dig  output  16  BCD count {MT,MU,ST,SU}: minute tens, minute units, second tens, second units.
REQ-011 SHALL have port Running  output  1  high while state is RUN.
REQ-012 SHALL have port Done  output  1  one-cycle pulse on entry to DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE, DONE.
REQ-014 SHALL give commands priority Clr > Load > Stop > Start when asserted in the same cycle.
REQ-015 Clr, any state: Dig = 0, prescaler = 0, next state IDLE.
REQ-016 Load, in IDLE/PAUSE/DONE: Dig = Pre, each digit saturated to its limit (SU,MU ≤ 9; ST,MT ≤ 5), prescaler = 0, next state IDLE; Load in RUN SHALL be ignored.
REQ-017 Start, in IDLE/PAUSE: latch M into dir register, next state RUN.
REQ-017a Exception to REQ-017: if the terminal value for the latched direction is already present (up: 59:59, down: 00:00), next state SHALL be DONE, with the Done pulse.
REQ-018 Start in RUN or DONE SHALL be ignored.
REQ-019 Stop in RUN: next state PAUSE, Dig and prescaler hold; Stop elsewhere SHALL be ignored.
REQ-020 Prescaler: counts 0..DIV-1 only in RUN; tick asserted in the cycle count == DIV-1, count then wraps to 0.
REQ-021 Prescaler SHALL hold in PAUSE and be 0 in IDLE/DONE.
REQ-022 On tick, up: SU increments; SU 9→0 carries into ST; ST 5→0 into MU; MU 9→0 into MT.
REQ-023 On tick, down: SU decrements; SU 0→9 borrows from ST; ST 0→5 from MU; MU 0→9 from MT.
REQ-024 Dig SHALL update in the cycle following the tick edge, i.e. tick-to-Dig latency 1 clock.
REQ-025 Tick producing 59:59 (up) or 00:00 (down) SHALL move the FSM to DONE in the same edge, with Done = 1 for exactly one cycle.
REQ-026 In DONE, Dig SHALL hold the terminal value; only Clr or Load exits.
REQ-027 Stop asserted in the same cycle as a tick SHALL win: no count update, next state PAUSE.

Reset
REQ-028 nRST low SHALL immediately force: state IDLE, Dig = 0, prescaler = 0, dir = up, Running = 0, Done = 0, regardless of CLK.
REQ-029 Deassertion SHALL take effect on the first CLK edge after nRST goes high; reset mid-RUN SHALL discard all progress.

Structure
REQ-030 SHALL place the following in shared package sw_pkg: state enum (IDLE, RUN, PAUSE, DONE) and digit-limit constants (9, 5).
REQ-031 SHALL instantiate sub-module stopwatch_digit four times.
REQ-031a stopwatch_digit: mod-(LIM+1) BCD digit with en, dir, load, load value, clr, and carry/borrow out.

Verification (DIV = 4)
REQ-032 Reset: nRST low mid-RUN at Dig = 00:07 -> Dig = 0000, Running = 0 without a CLK edge; state IDLE.
REQ-033 Up count: Clr, then Start with M = 1 -> Running = 1; after 40 cycles Dig = 00:10; after 240 cycles Dig = 01:00.
REQ-034 Down borrow: Load Pre = 01:00, Start with M = 0 -> one tick later Dig = 00:59.
REQ-035 Down terminal: Load 00:01, Start M = 0 -> Dig = 00:00, Done high for one cycle, state DONE; a further Start is ignored; Load 00:05 returns to IDLE.
REQ-036 Up terminal and saturation: Load Pre = 7E:9F (invalid) -> Dig = 59:59; Start M = 1 -> immediate DONE with Done pulse; Load 59:58 then Start -> one tick later 59:59 and DONE.
REQ-037 Pause/priority: RUN, Stop at prescaler = 2 -> Dig and prescaler hold for 20 cycles in PAUSE; Start resumes with tick 1 cycle later; Clr + Start in the same cycle -> Dig = 0, state IDLE.
